// File: rtl/mm_sequencer.sv
// ---------------------------------------------------------------------------
// mm_sequencer
//
// Purpose: sequences one matrix-multiply operation. It loads W_ROWS weight
// rows from the weight buffer into the MMU through the weight FIFO. It then
// streams num_rows data rows from the unified buffer through the data FIFO
// into the MMU, and writes the MMU result rows to the accumulator.
//
// Optional feature (macro WEIGHT_REUSE_EN): adds input reuse_w. When reuse_w
// is 1 at start, the operation skips LOAD_W and keeps the MMU weights that
// are already loaded.
//
// Ports:
//   clk                 sole clock, rising edge
//   reset               synchronous, active-high; aborts any operation
//   start               request pulse (sampled only in IDLE)
//   wb_base/ub_base     WB / UB start addresses (8 bit)
//   acc_base            accumulator start address (8 bit)
//   num_rows            data rows to stream (0 = illegal request)
//   accumulate          1 = add into accumulator, 0 = overwrite
//   reuse_w             (WEIGHT_REUSE_EN only) skip the weight load
//   read_wb .. acc_en   registered datapath enables
//   addra               accumulator write address (0 unless write_acc)
//   addrb               WB/UB read address (0 unless read_wb/read_ub)
//   busy                operation in progress
//   done                one-cycle completion pulse
//   err                 one-cycle illegal-request pulse
//
// Handshake: start is a level sampled on each rising edge. It is acted on
// only while the FSM is in IDLE, so a start raised while busy is dropped.
// An accepted request gives exactly one done pulse, unless reset aborts
// the operation. A request with num_rows=0 gives one err pulse instead,
// and the FSM stays in IDLE.
//
// Timing: every output is a register. It is loaded from a decode of the
// current state and cnt, so outputs trail the internal state by one cycle.
// ---------------------------------------------------------------------------
module mm_sequencer #(
  parameter int W_ROWS     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int MMU_LAT    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] wb_base,
  input  logic [7:0] ub_base,
  input  logic [7:0] acc_base,
  input  logic [7:0] num_rows,
  input  logic       accumulate,
`ifdef WEIGHT_REUSE_EN
  input  logic       reuse_w,
`endif
  output logic       read_wb,
  output logic       weight_fifo_en,
  output logic       mmu_load_weight_en,
  output logic       read_ub,
  output logic       data_fifo_en,
  output logic       mm_en,
  output logic       write_acc,
  output logic       acc_en,
  output logic [7:0] addra,
  output logic [7:0] addrb,
  output logic       busy,
  output logic       done,
  output logic       err
);

  // Counter wide enough for the longest COMPUTE phase (255+FIFO+latency).
  localparam int CW = 16;

  localparam logic [CW-1:0] C_W_ROWS  = CW'(W_ROWS);
  localparam logic [CW-1:0] C_FD      = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] C_ML      = CW'(MMU_LAT);
  localparam logic [CW-1:0] C_ONE     = CW'(1);
  localparam logic [CW-1:0] C_LW_LAST = CW'(W_ROWS + FIFO_DEPTH);
  localparam logic [CW-1:0] C_MM_LO   = CW'(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] C_WR_LO   = CW'(FIFO_DEPTH + MMU_LAT + 1);
  localparam logic [7:0]    C_WR_OFF  = 8'(FIFO_DEPTH + MMU_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD_W  = 2'd1,
    S_COMPUTE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_accept;
  logic          w_err_nxt;
  logic          w_reuse;

  // Operation parameters captured at accept time.
  logic [7:0]    r_wb_base;
  logic [7:0]    r_ub_base;
  logic [7:0]    r_acc_base;
  logic [7:0]    r_num_rows;
  logic          r_accumulate;

  // Derived COMPUTE bounds.
  logic [CW-1:0] w_n;
  logic [CW-1:0] w_n_fd;
  logic [CW-1:0] w_n_fd_ml;

  // Decoded (pre-register) outputs.
  logic          w_read_wb;
  logic          w_weight_fifo_en;
  logic          w_mmu_load_weight_en;
  logic          w_read_ub;
  logic          w_data_fifo_en;
  logic          w_mm_en;
  logic          w_write_acc;
  logic          w_acc_en;
  logic [7:0]    w_addra;
  logic [7:0]    w_addrb;
  logic          w_busy;
  logic          w_done;

  // Output registers.
  logic          r_read_wb;
  logic          r_weight_fifo_en;
  logic          r_mmu_load_weight_en;
  logic          r_read_ub;
  logic          r_data_fifo_en;
  logic          r_mm_en;
  logic          r_write_acc;
  logic          r_acc_en;
  logic [7:0]    r_addra;
  logic [7:0]    r_addrb;
  logic          r_busy;
  logic          r_done;
  logic          r_err;

`ifdef WEIGHT_REUSE_EN
  // The weight-reuse choice only steers the IDLE exit, so it is used as
  // sampled on the accepting edge.
  assign w_reuse = reuse_w;
`else
  assign w_reuse = 1'b0;
`endif

  assign w_n       = CW'(r_num_rows);
  assign w_n_fd    = w_n + C_FD;
  assign w_n_fd_ml = w_n_fd + C_ML;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state. cnt returns to 0 on every state entry.
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + C_ONE;
    w_accept    = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (start) begin
          if (num_rows == 8'd0) begin
            w_err_nxt = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = w_reuse ? S_COMPUTE : S_LOAD_W;
          end
        end
      end
      S_LOAD_W: begin
        if (r_cnt == C_LW_LAST) begin
          w_state_nxt = S_COMPUTE;
          w_cnt_nxt   = '0;
        end
      end
      S_COMPUTE: begin
        if (r_cnt == w_n_fd_ml) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Request capture
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb_base    <= '0;
      r_ub_base    <= '0;
      r_acc_base   <= '0;
      r_num_rows   <= '0;
      r_accumulate <= 1'b0;
    end else if (w_accept) begin
      r_wb_base    <= wb_base;
      r_ub_base    <= ub_base;
      r_acc_base   <= acc_base;
      r_num_rows   <= num_rows;
      r_accumulate <= accumulate;
    end
  end

  // -------------------------------------------------------------------------
  // Output decode from the current state/cnt. Addresses are 8-bit sums, so
  // they wrap modulo 256 naturally.
  // -------------------------------------------------------------------------
  always_comb begin
    w_read_wb            = 1'b0;
    w_weight_fifo_en     = 1'b0;
    w_mmu_load_weight_en = 1'b0;
    w_read_ub            = 1'b0;
    w_data_fifo_en       = 1'b0;
    w_mm_en              = 1'b0;
    w_write_acc          = 1'b0;
    w_acc_en             = 1'b0;
    w_addra              = '0;
    w_addrb              = '0;
    w_busy               = 1'b0;
    w_done               = 1'b0;
    case (r_state)
      S_LOAD_W: begin
        w_busy = 1'b1;
        if (r_cnt < C_W_ROWS) begin
          w_read_wb = 1'b1;
          w_addrb   = r_wb_base + r_cnt[7:0];
        end
        w_weight_fifo_en     = (r_cnt >= C_ONE) && (r_cnt <= C_LW_LAST);
        w_mmu_load_weight_en = (r_cnt >= C_MM_LO) && (r_cnt <= C_LW_LAST);
      end
      S_COMPUTE: begin
        w_busy = 1'b1;
        if (r_cnt < w_n) begin
          w_read_ub = 1'b1;
          w_addrb   = r_ub_base + r_cnt[7:0];
        end
        w_data_fifo_en = (r_cnt >= C_ONE) && (r_cnt <= w_n_fd);
        w_mm_en        = (r_cnt >= C_MM_LO) && (r_cnt <= w_n_fd_ml);
        if ((r_cnt >= C_WR_LO) && (r_cnt <= w_n_fd_ml)) begin
          w_write_acc = 1'b1;
          w_acc_en    = r_accumulate;
          // Result row index is cnt minus the FIFO and MMU pipeline depth.
          w_addra     = r_acc_base + (r_cnt[7:0] - C_WR_OFF);
        end
      end
      S_DONE: begin
        w_done = 1'b1;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_read_wb            <= 1'b0;
      r_weight_fifo_en     <= 1'b0;
      r_mmu_load_weight_en <= 1'b0;
      r_read_ub            <= 1'b0;
      r_data_fifo_en       <= 1'b0;
      r_mm_en              <= 1'b0;
      r_write_acc          <= 1'b0;
      r_acc_en             <= 1'b0;
      r_addra              <= '0;
      r_addrb              <= '0;
      r_busy               <= 1'b0;
      r_done               <= 1'b0;
      r_err                <= 1'b0;
    end else begin
      r_read_wb            <= w_read_wb;
      r_weight_fifo_en     <= w_weight_fifo_en;
      r_mmu_load_weight_en <= w_mmu_load_weight_en;
      r_read_ub            <= w_read_ub;
      r_data_fifo_en       <= w_data_fifo_en;
      r_mm_en              <= w_mm_en;
      r_write_acc          <= w_write_acc;
      r_acc_en             <= w_acc_en;
      r_addra              <= w_addra;
      r_addrb              <= w_addrb;
      r_busy               <= w_busy;
      r_done               <= w_done;
      r_err                <= w_err_nxt;
    end
  end

  assign read_wb            = r_read_wb;
  assign weight_fifo_en     = r_weight_fifo_en;
  assign mmu_load_weight_en = r_mmu_load_weight_en;
  assign read_ub            = r_read_ub;
  assign data_fifo_en       = r_data_fifo_en;
  assign mm_en              = r_mm_en;
  assign write_acc          = r_write_acc;
  assign acc_en             = r_acc_en;
  assign addra              = r_addra;
  assign addrb              = r_addrb;
  assign busy               = r_busy;
  assign done               = r_done;
  assign err                = r_err;

endmodule

// File: tb/tb_mm_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mm_sequencer: directed self-checking bench for mm_sequencer
// (W_ROWS=16, FIFO_DEPTH=4, MMU_LAT=16).
//
// Time t counts rising edges after the edge that samples start. t=0 is
// just after that edge. Outputs trail the internal state by one cycle, so
// LOAD_W cnt c shows at t=c+1, and COMPUTE cnt c shows at t=L+1+c. Here
// L=21 when weights are loaded and L=0 when they are reused.
// ---------------------------------------------------------------------------
module tb_mm_sequencer;

  localparam int W_ROWS     = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int MMU_LAT    = 16;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start;
  logic [7:0] wb_base;
  logic [7:0] ub_base;
  logic [7:0] acc_base;
  logic [7:0] num_rows;
  logic       accumulate;
`ifdef WEIGHT_REUSE_EN
  logic       reuse_w;
`endif
  logic       read_wb;
  logic       weight_fifo_en;
  logic       mmu_load_weight_en;
  logic       read_ub;
  logic       data_fifo_en;
  logic       mm_en;
  logic       write_acc;
  logic       acc_en;
  logic [7:0] addra;
  logic [7:0] addrb;
  logic       busy;
  logic       done;
  logic       err;

  mm_sequencer #(
    .W_ROWS     (W_ROWS),
    .FIFO_DEPTH (FIFO_DEPTH),
    .MMU_LAT    (MMU_LAT)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .wb_base            (wb_base),
    .ub_base            (ub_base),
    .acc_base           (acc_base),
    .num_rows           (num_rows),
    .accumulate         (accumulate),
`ifdef WEIGHT_REUSE_EN
    .reuse_w            (reuse_w),
`endif
    .read_wb            (read_wb),
    .weight_fifo_en     (weight_fifo_en),
    .mmu_load_weight_en (mmu_load_weight_en),
    .read_ub            (read_ub),
    .data_fifo_en       (data_fifo_en),
    .mm_en              (mm_en),
    .write_acc          (write_acc),
    .acc_en             (acc_en),
    .addra              (addra),
    .addrb              (addrb),
    .busy               (busy),
    .done               (done),
    .err                (err)
  );

  // -------------------------------------------------------------------------
  // Scoreboard state
  // -------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] wb_q[$];
  logic [7:0] ub_q[$];
  logic [7:0] acc_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [26:0] all_outs();
    return {read_wb, weight_fifo_en, mmu_load_weight_en, read_ub, data_fifo_en,
            mm_en, write_acc, acc_en, addra, addrb, busy, done, err};
  endfunction

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one accepted operation and checks every enable window, every
  // address, busy, done timing and acc_en. restart_t >= 1 re-raises start
  // (with different inputs) at that t while the operation is busy.
  task automatic run_op(input string tag, input logic [7:0] wb, input logic [7:0] ub,
                        input logic [7:0] acc, input logic [7:0] n, input logic accum,
                        input logic reuse, input int restart_t);
    int L;
    int done_exp;
    int done_cnt;
    int done_t;
    int busy_bad;
    int accen_bad;
    int addr_bad;
    int err_cnt;
    int first_t[8];
    int cnt_e[8];
    int exp_first[8];
    int exp_cnt[8];
    logic [7:0] en;
    logic [7:0] e;
    L        = reuse ? 0 : (W_ROWS + FIFO_DEPTH + 1);
    done_exp = L + int'(n) + FIFO_DEPTH + MMU_LAT + 2;
    done_cnt = 0; done_t = -1; busy_bad = 0; accen_bad = 0; addr_bad = 0; err_cnt = 0;
    wb_q.delete(); ub_q.delete(); acc_q.delete();
    if (!reuse) for (int i = 0; i < W_ROWS; i++) wb_q.push_back(wb + 8'(i));
    for (int i = 0; i < int'(n); i++) begin
      ub_q.push_back(ub + 8'(i));
      acc_q.push_back(acc + 8'(i));
    end
    exp_cnt[0] = reuse ? 0 : W_ROWS;              exp_first[0] = 1;
    exp_cnt[1] = reuse ? 0 : W_ROWS + FIFO_DEPTH; exp_first[1] = 2;
    exp_cnt[2] = reuse ? 0 : W_ROWS;              exp_first[2] = FIFO_DEPTH + 2;
    exp_cnt[3] = int'(n);                         exp_first[3] = L + 1;
    exp_cnt[4] = int'(n) + FIFO_DEPTH;            exp_first[4] = L + 2;
    exp_cnt[5] = int'(n) + MMU_LAT;               exp_first[5] = L + FIFO_DEPTH + 2;
    exp_cnt[6] = int'(n);                         exp_first[6] = L + FIFO_DEPTH + MMU_LAT + 2;
    exp_cnt[7] = accum ? int'(n) : 0;             exp_first[7] = L + FIFO_DEPTH + MMU_LAT + 2;
    for (int k = 0; k < 8; k++) begin
      first_t[k] = -1;
      cnt_e[k]   = 0;
    end
    wb_base = wb; ub_base = ub; acc_base = acc; num_rows = n; accumulate = accum;
`ifdef WEIGHT_REUSE_EN
    reuse_w = reuse;
`endif
    start = 1'b1;
    step();
    start = 1'b0;
    for (int t = 1; t <= done_exp + 3; t++) begin
      step();
      en = {acc_en, write_acc, mm_en, data_fifo_en, read_ub, mmu_load_weight_en,
            weight_fifo_en, read_wb};
      for (int k = 0; k < 8; k++) begin
        if (en[k]) begin
          if (first_t[k] < 0) first_t[k] = t;
          cnt_e[k]++;
        end
      end
      if (read_wb) begin
        e = (wb_q.size() > 0) ? wb_q.pop_front() : 8'hxx;
        chk({tag, "_wb_addr"}, 32'(addrb), 32'(e));
      end
      if (read_ub) begin
        e = (ub_q.size() > 0) ? ub_q.pop_front() : 8'hxx;
        chk({tag, "_ub_addr"}, 32'(addrb), 32'(e));
      end
      if (write_acc) begin
        e = (acc_q.size() > 0) ? acc_q.pop_front() : 8'hxx;
        chk({tag, "_acc_addr"}, 32'(addra), 32'(e));
      end
      if (!read_wb && !read_ub && addrb !== 8'h00) addr_bad++;
      if (!write_acc && addra !== 8'h00) addr_bad++;
      if (acc_en !== (write_acc & accum)) accen_bad++;
      if (busy !== (t < done_exp)) busy_bad++;
      if (done === 1'b1) begin
        done_cnt++;
        done_t = t;
      end
      if (err !== 1'b0) err_cnt++;
      // A start while busy must be ignored; the changed inputs would show.
      if (t == restart_t) begin
        start = 1'b1; num_rows = 8'd9; wb_base = 8'h55; ub_base = 8'h66; acc_base = 8'h77;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s_en%0d_count", tag, k), 32'(cnt_e[k]), 32'(exp_cnt[k]));
      if (exp_cnt[k] > 0)
        chk($sformatf("%s_en%0d_first", tag, k), 32'(first_t[k]), 32'(exp_first[k]));
    end
    chk({tag, "_wb_left"},  32'(wb_q.size()),  32'd0);
    chk({tag, "_ub_left"},  32'(ub_q.size()),  32'd0);
    chk({tag, "_acc_left"}, 32'(acc_q.size()), 32'd0);
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({tag, "_done_t"},   32'(done_t),   32'(done_exp));
    chk({tag, "_busy_bad"}, 32'(busy_bad), 32'd0);
    chk({tag, "_accen_bad"}, 32'(accen_bad), 32'd0);
    chk({tag, "_addr_zero"}, 32'(addr_bad), 32'd0);
    chk({tag, "_err_cnt"},  32'(err_cnt), 32'd0);
  endtask

  // -------------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------------
  initial begin
    int bad;
    int dn;
    reset = 1'b1; start = 1'b0; wb_base = '0; ub_base = '0; acc_base = '0;
    num_rows = '0; accumulate = 1'b0;
`ifdef WEIGHT_REUSE_EN
    reuse_w = 1'b0;
`endif
    step(); step(); step();
    chk("reset_outs", 32'(all_outs()), 32'd0);

    // Reset wins over start in the same cycle.
    start = 1'b1; num_rows = 8'd2;
    step();
    start = 1'b0; reset = 1'b0;
    chk("rst_prio_outs", 32'(all_outs()), 32'd0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (all_outs() !== 27'd0) bad++;
    end
    chk("rst_prio_idle", 32'(bad), 32'd0);

    // Basic run.
    run_op("basic", 8'h10, 8'h20, 8'h30, 8'd3, 1'b0, 1'b0, -1);
    // Address wrap on WB, UB and accumulator.
    run_op("wrap", 8'hF8, 8'hFE, 8'hFF, 8'd3, 1'b1, 1'b0, -1);

    // Illegal request.
    num_rows = 8'd0; wb_base = 8'h10; start = 1'b1;
    step();
    start = 1'b0;
    chk("illegal_err_t0", 32'(err), 32'd1);
    chk("illegal_busy_t0", 32'(busy), 32'd0);
    step();
    chk("illegal_err_t1", 32'(err), 32'd0);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (all_outs() !== 27'd0) bad++;
    end
    chk("illegal_quiet", 32'(bad), 32'd0);

    // Mid-run reset at COMPUTE cnt=5 (t=26 with L=21).
    wb_base = 8'h00; ub_base = 8'h40; acc_base = 8'h80; num_rows = 8'd4;
    accumulate = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int t = 1; t <= 26; t++) step();
    chk("midrst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_outs", 32'(all_outs()), 32'd0);
    bad = 0; dn = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (all_outs() !== 27'd0) bad++;
      if (done === 1'b1) dn++;
    end
    chk("midrst_quiet", 32'(bad), 32'd0);
    chk("midrst_no_done", 32'(dn), 32'd0);
    run_op("after_rst", 8'h00, 8'h40, 8'h80, 8'd1, 1'b0, 1'b0, -1);

    // Start while busy is ignored; accumulate mirrors write_acc.
    run_op("busy_acc", 8'h01, 8'h02, 8'h03, 8'd2, 1'b1, 1'b0, 10);

`ifdef WEIGHT_REUSE_EN
    run_op("reuse", 8'h11, 8'h60, 8'h70, 8'd2, 1'b0, 1'b1, -1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
